ifu_fetch: RTL and testbench

//  Instruction fetch unit: producer side of the IF/ID valid/ready interface. Owns the PC and issues
//  one single-outstanding request at a time to instruction memory. Presents {inst, pc, pred_pc}

---
 rtl/ifu_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch : instruction fetch unit, producer side of the IF/ID valid/ready link.
//
// Owns the PC and keeps at most one instruction-memory request outstanding.
// A fetched instruction is presented as {f_inst_o, f_pc_o, f_pred_pc_o} with
// f_valid_o and held until IF/ID accepts it. An execute-stage redirect flushes
// whatever fetch is in flight or held and restarts at the new target.
//
// Optional feature macro: YSYX_23060251_BTFN_PRED_EN
//   defined   : static backward-taken / forward-not-taken prediction
//               (JAL -> pc+imm_J, backward B-type -> pc+imm_B, else pc+4)
//   undefined : f_pred_pc_o = f_pc_o + 4
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   imem_req_valid_o  fetch request valid
//   imem_req_ready_i  memory accepts request
//   imem_addr_o       fetch address (word aligned)
//   imem_rsp_valid_i  response valid
//   imem_rsp_data_i   fetched instruction
//   imem_rsp_ready_o  fetch accepts response
//   f_inst_o          instruction to IF/ID
//   f_pc_o            pc of f_inst_o
//   f_pred_pc_o       predicted next pc
//   f_valid_o         fetch packet valid
//   D_ready_i         IF/ID can accept
//   redirect_valid_i  flush + new pc from execute
//   redirect_pc_i     redirect target (bits [1:0] ignored)
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            imem_rsp_ready_o,
  output logic [XLEN-1:0] f_inst_o,
  output logic [XLEN-1:0] f_pc_o,
  output logic [XLEN-1:0] f_pred_pc_o,
  output logic            f_valid_o,
  input  logic            D_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] INST_LEN = XLEN'(32'd4);

  state_e          state_r;
  state_e          state_n;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] f_pc_r;
  logic [XLEN-1:0] pred_r;
  // State-decode flags registered alongside the state so outputs come from flops.
  logic            req_en_r;
  logic            rsp_en_r;
  logic            hold_r;
  logic            live_r;

  logic [XLEN-1:0] redir_tgt_s;
  logic            redir_s;
  logic            capture_s;
  logic            accept_s;
  logic [XLEN-1:0] pred_calc_s;

`ifdef YSYX_23060251_BTFN_PRED_EN
  // Static BTFN next-pc guess for an instruction fetched at pc.
  function automatic logic [XLEN-1:0] btfn_predict(input logic [XLEN-1:0] inst,
                                                   input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] off;
    if (inst[6:0] == 7'b1101111) begin
      off = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    end else if ((inst[6:0] == 7'b1100011) && inst[31]) begin
      off = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    end else begin
      off = INST_LEN;
    end
    return (pc + off) & PC_MASK;
  endfunction
`endif

  // Redirect is ignored only while leaving reset; it wins over every other event.
  assign redir_tgt_s = redirect_pc_i & PC_MASK;
  assign redir_s     = redirect_valid_i && (state_r != ST_RST);
  assign capture_s   = (state_r == ST_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
  assign accept_s    = (state_r == ST_HOLD) && D_ready_i && !redirect_valid_i;

`ifdef YSYX_23060251_BTFN_PRED_EN
  assign pred_calc_s = btfn_predict(imem_rsp_data_i, pc_r);
`else
  assign pred_calc_s = (pc_r + INST_LEN) & PC_MASK;
`endif

  // Next-state selection for the fetch FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_RST: begin
        state_n = ST_REQ;
      end
      ST_REQ: begin
        if (!redirect_valid_i && imem_req_ready_i) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid_i) begin
          // A response arriving together with the redirect is simply discarded.
          state_n = imem_rsp_valid_i ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid_i) begin
          state_n = ST_HOLD;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid_i) begin
          state_n = ST_REQ;
        end else begin
          state_n = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i || D_ready_i) begin
          state_n = ST_REQ;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_RST;
      end
    endcase
  end

  // State, decode flags, PC and held fetch packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_RST;
      req_en_r <= 1'b0;
      rsp_en_r <= 1'b0;
      hold_r   <= 1'b0;
      live_r   <= 1'b0;
      pc_r     <= RESET_PC & PC_MASK;
      inst_r   <= NOP_INST;
      f_pc_r   <= '0;
      pred_r   <= '0;
    end else begin
      state_r  <= state_n;
      req_en_r <= (state_n == ST_REQ);
      rsp_en_r <= (state_n == ST_WAIT) || (state_n == ST_DROP);
      hold_r   <= (state_n == ST_HOLD);
      live_r   <= 1'b1;

      if (redir_s) begin
        pc_r <= redir_tgt_s;
      end else if (accept_s) begin
        pc_r <= pred_r;
      end else begin
        pc_r <= pc_r;
      end

      if (capture_s) begin
        inst_r <= imem_rsp_data_i;
        f_pc_r <= pc_r;
        pred_r <= pred_calc_s;
      end else begin
        inst_r <= inst_r;
        f_pc_r <= f_pc_r;
        pred_r <= pred_r;
      end
    end
  end

  // A redirect in the same cycle suppresses both the request and the packet.
  assign imem_req_valid_o = req_en_r && !redirect_valid_i;
  assign imem_addr_o      = req_en_r ? pc_r : '0;
  assign imem_rsp_ready_o = rsp_en_r;
  assign f_valid_o        = hold_r && !redirect_valid_i;
  assign f_inst_o         = live_r ? inst_r : '0;
  assign f_pc_o           = f_pc_r;
  assign f_pred_pc_o      = pred_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch : directed + randomized bench for ifu_fetch.
// A behavioural memory answers requests after a programmable latency; a
// reference model tracks the architectural "next pc to deliver" and checks
// every request address and every delivered packet against it.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_ready_o;
  logic [31:0] f_inst_o;
  logic [31:0] f_pc_o;
  logic [31:0] f_pred_pc_o;
  logic        f_valid_o;
  logic        D_ready_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;

  ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .f_inst_o         (f_inst_o),
    .f_pc_o           (f_pc_o),
    .f_pred_pc_o      (f_pred_pc_o),
    .f_valid_o        (f_valid_o),
    .D_ready_i        (D_ready_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // memory model state
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat_k    = 1;
  bit          acc      = 1'b0;
  bit          cons     = 1'b0;
  logic [31:0] acc_addr = '0;

  // reference model state
  logic [31:0] exp_pc = RST_PC;
  bit          held_v = 1'b0;
  logic [31:0] held_pc, held_inst, held_pred;
  int          deliveries = 0;
  int          dq_cyc[$];
  logic [31:0] dq_pc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Program image: NOPs near the reset vector, one backward beq, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a == 32'h8000_0010) return 32'hFE00_0EE3;
    if (a[31:16] == 16'h8000) return 32'h0000_0013;
    h = (a * 32'h9E37_79B1) ^ (a >> 7);
    if (a[31:28] == 4'hF)       op = 7'h13;
    else if (a[4:3] == 2'd0)    op = 7'h6F;
    else if (a[4:3] == 2'd1)    op = 7'h63;
    else                        op = 7'h13;
    return {h[31:7], op};
  endfunction

  // Architectural next pc after executing inst at pc (as the predictor sees it).
  function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] inst);
    int offset;
    logic signed [20:0] j_imm;
    logic signed [12:0] b_imm;
    offset = 4;
    j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
`ifdef YSYX_23060251_BTFN_PRED_EN
    if (inst[6:0] == 7'b1101111) offset = int'(j_imm);
    else if (inst[6:0] == 7'b1100011 && b_imm < 0) offset = int'(b_imm);
`endif
    return (pc + offset) & 32'hFFFF_FFFC;
  endfunction

  // Sample outputs mid-cycle, check against the model, then advance the model.
  task automatic sample();
    logic [31:0] pw;
    @(negedge clk_i);
    acc  = 1'b0;
    cons = 1'b0;
    if (rst_i) begin
      exp_pc = RST_PC;
      held_v = 1'b0;
    end else begin
      if (imem_req_valid_o === 1'b1) begin
        check("req_single_outstanding", 32'(mem_busy), 32'd0);
        check("req_addr_model", imem_addr_o, exp_pc);
      end
      if (imem_rsp_valid_i) check("rsp_ready_when_rsp", 32'(imem_rsp_ready_o), 32'd1);
      if (held_v) begin
        check("hold_pc_stable", f_pc_o, held_pc);
        check("hold_inst_stable", f_inst_o, held_inst);
        check("hold_pred_stable", f_pred_pc_o, held_pred);
      end
      pw = mem_word(exp_pc);
      if (f_valid_o === 1'b1) begin
        check("pkt_pc", f_pc_o, exp_pc);
        check("pkt_inst", f_inst_o, pw);
        check("pkt_pred", f_pred_pc_o, ref_pred(exp_pc, pw));
      end
      acc      = (imem_req_valid_o === 1'b1) && imem_req_ready_i;
      acc_addr = imem_addr_o;
      cons     = imem_rsp_valid_i && (imem_rsp_ready_o === 1'b1);
      held_v    = (f_valid_o === 1'b1) && !D_ready_i;
      held_pc   = f_pc_o;
      held_inst = f_inst_o;
      held_pred = f_pred_pc_o;
      if (redirect_valid_i) begin
        exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else if ((f_valid_o === 1'b1) && D_ready_i) begin
        deliveries++;
        dq_cyc.push_back(cyc);
        dq_pc.push_back(f_pc_o);
        exp_pc = ref_pred(exp_pc, pw);
      end
    end
  endtask

  // Clock edge, then memory bookkeeping and input defaults for the new cycle.
  task automatic adv();
    @(posedge clk_i);
    #1;
    cyc++;
    if (rst_i) begin
      mem_busy = 1'b0;
      mem_cnt  = 0;
    end else begin
      if (cons) mem_busy = 1'b0;
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = acc_addr;
        mem_cnt  = lat_k;
      end
    end
    if (mem_busy && mem_cnt > 0) mem_cnt--;
    imem_rsp_valid_i = mem_busy && (mem_cnt == 0);
    imem_rsp_data_i  = mem_busy ? mem_word(mem_addr) : 32'h0;
    redirect_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (f_valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (i < 39) adv();
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int          rel;
    int          d0;
    logic [31:0] exp6;
    logic [31:0] p0;
`ifdef YSYX_23060251_BTFN_PRED_EN
    exp6 = 32'h8000_000C;
`else
    exp6 = 32'h8000_0014;
`endif
    rst_i = 1'b1; imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0; D_ready_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst_f_valid", 32'(f_valid_o), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      adv();
    end
    rst_i = 1'b0;
    rel = cyc;
    sample();
    check("rststate_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rststate_f_valid", 32'(f_valid_o), 32'd0);
    check("rststate_rsp_ready", 32'(imem_rsp_ready_o), 32'd0);
    check("rststate_inst", f_inst_o, 32'd0);
    adv();
    sample();
    check("first_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("first_req_addr", imem_addr_o, 32'h8000_0000);
    adv();

    // zero-wait streaming: three packets, 3 cycles apart
    for (int i = 0; i < 8; i++) begin sample(); adv(); end
    check("stream_count", 32'(deliveries), 32'd3);
    if (deliveries >= 3) begin
      check("stream_latency", 32'(dq_cyc[0] - rel), 32'd3);
      check("stream_pc0", dq_pc[0], 32'h8000_0000);
      check("stream_pc1", dq_pc[1], 32'h8000_0004);
      check("stream_pc2", dq_pc[2], 32'h8000_0008);
      check("stream_gap1", 32'(dq_cyc[1] - dq_cyc[0]), 32'd3);
      check("stream_gap2", 32'(dq_cyc[2] - dq_cyc[1]), 32'd3);
    end

    // backpressure: hold 5 cycles
    D_ready_i = 1'b0;
    wait_valid("hold_wait_valid");
    p0 = f_pc_o;
    check("hold_pc", p0, 32'h8000_000C);
    for (int i = 0; i < 4; i++) begin
      adv();
      sample();
      check("hold_f_valid", 32'(f_valid_o), 32'd1);
      check("hold_pc_same", f_pc_o, p0);
      check("hold_no_req", 32'(imem_req_valid_o), 32'd0);
    end
    adv();
    D_ready_i = 1'b1;
    sample();
    adv();
    sample();
    check("after_hold_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("after_hold_req_addr", imem_addr_o, 32'h8000_0010);
    adv();

    // backward branch prediction
    D_ready_i = 1'b0;
    wait_valid("beq_wait_valid");
    check("beq_inst", f_inst_o, 32'hFE00_0EE3);
    check("beq_pc", f_pc_o, 32'h8000_0010);
    check("beq_pred", f_pred_pc_o, exp6);
    adv();
    D_ready_i = 1'b1;
    sample();
    adv();
    sample();
    check("beq_next_addr", imem_addr_o, exp6);
    lat_k = 2;
    adv();

    // redirect in WAIT, response two cycles after request
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_1003;
    d0 = deliveries;
    sample();
    check("wait_redir_f_valid", 32'(f_valid_o), 32'd0);
    adv();
    sample();
    check("drop_rsp_valid", 32'(imem_rsp_valid_i), 32'd1);
    check("drop_rsp_ready", 32'(imem_rsp_ready_o), 32'd1);
    check("drop_f_valid", 32'(f_valid_o), 32'd0);
    check("drop_no_req", 32'(imem_req_valid_o), 32'd0);
    adv();
    sample();
    check("drop_next_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("drop_next_req_addr", imem_addr_o, 32'h8000_1000);
    lat_k = 1;
    adv();

    // redirect coincident with response
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_2000;
    sample();
    check("rspredir_f_valid", 32'(f_valid_o), 32'd0);
    adv();
    sample();
    check("rspredir_req_addr", imem_addr_o, 32'h8000_2000);
    adv();
    sample();
    adv();

    // redirect coincident with D_ready in HOLD
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_3000;
    sample();
    check("holdredir_f_valid", 32'(f_valid_o), 32'd0);
    adv();
    sample();
    check("holdredir_req_addr", imem_addr_o, 32'h8000_3000);
    check("redir_no_delivery", 32'(deliveries), 32'(d0));
    adv();
    sample();
    adv();
    sample();
    adv();

    // redirect in REQ to the top of memory, then pc wraps to 0
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    sample();
    check("reqredir_no_req", 32'(imem_req_valid_o), 32'd0);
    adv();
    sample();
    check("wrap_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("wrap_req_addr", imem_addr_o, 32'hFFFF_FFFC);
    adv();
    wait_valid("wrap_wait_valid");
    adv();
    sample();
    check("wrap_next_addr", imem_addr_o, 32'h0000_0000);
    adv();

    // randomized traffic against the reference model
    d0 = deliveries;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      lat_k            = int'($urandom_range(1, 4));
      D_ready_i        = ($urandom_range(0, 2) != 0);
      redirect_valid_i = ($urandom_range(0, 9) == 0);
      redirect_pc_i    = ($urandom_range(0, 1) == 1) ? {16'h8000, 16'($urandom)} : 32'($urandom);
      sample();
      adv();
    end
    check("random_progress", 32'(deliveries > d0 + 20), 32'd1);

    // reset mid-operation
    rst_i = 1'b1; imem_req_ready_i = 1'b1; D_ready_i = 1'b1;
    sample();
    adv();
    rst_i = 1'b0;
    sample();
    check("rst2_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst2_f_valid", 32'(f_valid_o), 32'd0);
    adv();
    sample();
    check("rst2_req_addr", imem_addr_o, 32'h8000_0000);
    check("rst2_req_valid_on", 32'(imem_req_valid_o), 32'd1);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
